// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types for the data RAM arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester holds the RAM for the current access
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      AUD_RD = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_AUD = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter
//   Saturating counter that tracks how long the audio requester has waited.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   inc    : count one more waiting cycle (ignored once saturated)
//   clr    : clear to zero, has priority over inc
//   count  : current count
//   at_max : count has reached MAX_WAIT
module arb_wait_counter
   import ram_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   logic [CNT_W-1:0] count_reg;

   assign at_max = (count_reg == CNT_W'(MAX_WAIT));
   assign count  = count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && !at_max) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares a single-port data RAM between the CPU MEM stage and the audio
//   sample streamer. CPU has priority; audio is force-granted once it has
//   waited MAX_WAIT cycles.
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ready, cpu_stall : CPU port
//   aud_req/addr          -> aud_rdata, aud_valid            : audio read port
//   ram_addr/ram_data/ram_wren, ram_q                       : RAM port
//   Grant-cycle RAM signals are combinational from the requester inputs so the
//   address reaches the RAM in the same cycle the grant is decided.
module data_ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              aud_req,
   input  logic [ADDR_W-1:0] aud_addr,
   output logic [DATA_W-1:0] aud_rdata,
   output logic              aud_valid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int LAT_W = $clog2(RD_LAT + 1);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_t        state_reg, state_next;
   arb_owner_t        owner_reg, owner_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
   logic [DATA_W-1:0] cpu_rdata_reg, aud_rdata_reg;
   logic [CNT_W-1:0]  wait_cnt;
   logic              wait_at_max;
   logic              grant_aud, grant_cpu, aud_busy, capture;

   // Grants are suppressed while rst is high so nothing (notably a write)
   // reaches the RAM during the reset cycle.
   assign grant_aud = (state_reg == IDLE) && !rst && aud_req && (wait_at_max || !cpu_req);
   assign grant_cpu = (state_reg == IDLE) && !rst && cpu_req && !grant_aud;

   // Audio is "in service" through its read and its completion cycle, so the
   // still-held request does not count as waiting.
   assign aud_busy = (state_reg == AUD_RD) || (state_reg == RESP && owner_reg == OWN_AUD);

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_wait (
      .clk    (clk),
      .rst    (rst),
      .inc    (aud_req && !grant_aud && !aud_busy),
      .clr    (grant_aud),
      .count  (wait_cnt),
      .at_max (wait_at_max)
   );

   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      addr_next    = addr_reg;
      lat_cnt_next = lat_cnt_reg;
      ram_addr     = '0;
      ram_data     = '0;
      ram_wren     = 1'b0;
      capture      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_aud) begin
               ram_addr     = aud_addr;
               addr_next    = aud_addr;
               owner_next   = OWN_AUD;
               lat_cnt_next = LAT_W'(RD_LAT);
               state_next   = AUD_RD;
            end else if (grant_cpu) begin
               ram_addr   = cpu_addr;
               addr_next  = cpu_addr;
               owner_next = OWN_CPU;
               if (cpu_we) begin
                  ram_wren   = 1'b1;
                  ram_data   = cpu_wdata;
                  state_next = RESP;
               end else begin
                  lat_cnt_next = LAT_W'(RD_LAT);
                  state_next   = CPU_RD;
               end
            end
         end
         CPU_RD, AUD_RD: begin
            ram_addr = addr_reg;
            // Last latency cycle: ram_q now reflects the address issued at grant.
            if (lat_cnt_reg == LAT_W'(1)) begin
               lat_cnt_next = '0;
               capture      = 1'b1;
               state_next   = RESP;
            end else begin
               lat_cnt_next = lat_cnt_reg - LAT_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         owner_reg     <= OWN_CPU;
         addr_reg      <= '0;
         lat_cnt_reg   <= '0;
         cpu_rdata_reg <= '0;
         aud_rdata_reg <= '0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         addr_reg    <= addr_next;
         lat_cnt_reg <= lat_cnt_next;
         if (capture && state_reg == CPU_RD) begin
            cpu_rdata_reg <= ram_q;
         end
         if (capture && state_reg == AUD_RD) begin
            aud_rdata_reg <= ram_q;
         end
      end
   end

   assign cpu_ready = (state_reg == RESP) && (owner_reg == OWN_CPU);
   assign aud_valid = (state_reg == RESP) && (owner_reg == OWN_AUD);
   assign cpu_stall = cpu_req && !cpu_ready;
   assign cpu_rdata = cpu_rdata_reg;
   assign aud_rdata = aud_rdata_reg;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter
//   Drives the arbiter with directed and random CPU/audio traffic against a
//   behavioural RAM, and checks every output each cycle against a countdown
//   model of the arbitration rules.
module tb_data_ram_arbiter;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 16;
   localparam int RD_LAT   = 1;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we, aud_req;
   logic [ADDR_W-1:0] cpu_addr, aud_addr, ram_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata, aud_rdata, ram_data, ram_q;
   logic              cpu_ready, cpu_stall, aud_valid, ram_wren;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_ram_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RD_LAT   (RD_LAT),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_stall (cpu_stall),
      .aud_req   (aud_req),
      .aud_addr  (aud_addr),
      .aud_rdata (aud_rdata),
      .aud_valid (aud_valid),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q)
   );

   function automatic logic [DATA_W-1:0] init_word(int i);
      return DATA_W'(i * 40503 + 17);
   endfunction

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural single-port RAM, one-cycle registered read.
   logic [DATA_W-1:0] mem [256];
   bit                mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else begin
         if (ram_wren) mem[ram_addr[7:0]] <= ram_data;
         ram_q <= mem[ram_addr[7:0]];
      end
   end

   // Reference model: an access occupies the RAM for a fixed number of
   // cycles from its grant; the completion pulse comes in the last one.
   logic [DATA_W-1:0] shadow [256];
   bit                sh_init = 1'b0;
   int                m_rem, m_wait;
   bit                m_aud, m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_val, m_cpu_rd, m_aud_rd;
   int                cpu_pulses = 0, aud_pulses = 0;

   always @(negedge clk) begin
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      bit e_wren, e_rdy, e_vld, g_cpu, g_aud, busy;
      if (!sh_init) begin
         for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
         sh_init = 1'b1;
      end
      if (cpu_ready) cpu_pulses++;
      if (aud_valid) aud_pulses++;
      if (rst) begin
         m_rem = 0; m_wait = 0; m_aud = 0; m_we = 0; m_addr = '0;
         m_cpu_rd = '0; m_aud_rd = '0; m_val = '0;
      end else begin
         e_addr = '0; e_data = '0; e_wren = 0; e_rdy = 0; e_vld = 0;
         g_cpu = 0; g_aud = 0;
         busy = m_aud && (m_rem > 0);
         if (m_rem == 1) begin
            if (m_aud) begin
               e_vld = 1; m_aud_rd = m_val;
               $display("[TB] %0t aud rd addr=%05h data=%04h", $time, m_addr, m_val);
            end else begin
               e_rdy = 1;
               if (!m_we) m_cpu_rd = m_val;
               $display("[TB] %0t cpu %s addr=%05h data=%04h", $time,
                        m_we ? "wr" : "rd", m_addr, m_val);
            end
         end else if (m_rem > 1) begin
            e_addr = m_addr;
         end else begin
            if (aud_req && (m_wait == MAX_WAIT || !cpu_req)) g_aud = 1;
            else if (cpu_req) g_cpu = 1;
            if (g_aud) begin
               m_aud = 1; m_we = 0; m_addr = aud_addr;
               m_val = shadow[aud_addr[7:0]];
            end else if (g_cpu) begin
               m_aud = 0; m_we = cpu_we; m_addr = cpu_addr;
               if (cpu_we) begin
                  e_wren = 1; e_data = cpu_wdata; m_val = cpu_wdata;
                  shadow[cpu_addr[7:0]] = cpu_wdata;
               end else begin
                  m_val = shadow[cpu_addr[7:0]];
               end
            end
            if (g_aud || g_cpu) e_addr = m_addr;
         end
         check_eq("ram_addr",  32'(ram_addr),  32'(e_addr));
         check_eq("ram_data",  32'(ram_data),  32'(e_data));
         check_eq("ram_wren",  32'(ram_wren),  32'(e_wren));
         check_eq("cpu_ready", 32'(cpu_ready), 32'(e_rdy));
         check_eq("aud_valid", 32'(aud_valid), 32'(e_vld));
         check_eq("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_rdy));
         check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
         check_eq("aud_rdata", 32'(aud_rdata), 32'(m_aud_rd));
         check_eq("wait_cnt",  32'(dut.wait_cnt), 32'(m_wait));
         if (g_aud) m_wait = 0;
         else if (aud_req && !busy && m_wait < MAX_WAIT) m_wait++;
         if (m_rem > 0) m_rem--;
         if (g_aud) m_rem = RD_LAT + 1;
         else if (g_cpu) m_rem = cpu_we ? 1 : RD_LAT + 1;
      end
   end

   // Stimulus side: a request is dropped on the edge after its pulse.
   int cpu_ack = 0, aud_ack = 0;

   task automatic drop_done();
      if (cpu_req && cpu_pulses != cpu_ack) cpu_req = 0;
      if (aud_req && aud_pulses != aud_ack) aud_req = 0;
      cpu_ack = cpu_pulses;
      aud_ack = aud_pulses;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drop_done();
   endtask

   task automatic finish_reqs();
      for (int i = 0; i < 60; i++) begin
         if (!cpu_req && !aud_req) return;
         step();
      end
      check_eq("req_timeout", 32'(cpu_req || aud_req), 32'd0);
      cpu_req = 0;
      aud_req = 0;
   endtask

   task automatic cpu_start(logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   initial begin
      int aud_before;
      logic [DATA_W-1:0] exp_word;
      rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      aud_req = 0; aud_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Idle: nothing should move for 10 cycles.
      repeat (10) step();

      // Write then read back.
      cpu_start(1'b1, 19'h00010, 16'hBEEF);
      finish_reqs();
      cpu_start(1'b0, 19'h00010, 16'h0000);
      finish_reqs();
      check_eq("rd_beef", 32'(cpu_rdata), 32'h0000BEEF);
      step();

      // Simultaneous requests: CPU first, then audio.
      cpu_start(1'b0, 19'h00020, 16'h0);
      aud_req = 1; aud_addr = 19'h00030;
      finish_reqs();
      step();

      // Continuous CPU reads with audio pending: audio must still get in.
      aud_before = aud_pulses;
      aud_req = 1; aud_addr = 19'h00040;
      cpu_start(1'b0, 19'h00001, 16'h0);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (cpu_pulses != cpu_ack) begin
            cpu_ack = cpu_pulses;
            cpu_addr = ADDR_W'($urandom_range(0, 255));
         end
         if (aud_req && aud_pulses != aud_ack) aud_req = 0;
         aud_ack = aud_pulses;
      end
      finish_reqs();
      check_eq("aud_forced", 32'(aud_pulses > aud_before), 32'd1);
      step();

      // Reset in the middle of a CPU read.
      cpu_start(1'b0, 19'h00055, 16'h0);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0; cpu_req = 0;
      cpu_ack = cpu_pulses;
      @(negedge clk);
      check_eq("rst_ready", 32'(cpu_ready), 32'd0);
      check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
      step();
      exp_word = shadow[8'h55];
      cpu_start(1'b0, 19'h00055, 16'h0);
      finish_reqs();
      check_eq("rst_reread", 32'(cpu_rdata), 32'(exp_word));
      step();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         if (!cpu_req && $urandom_range(0, 3) == 0)
            cpu_start(1'($urandom), ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom));
         if (!aud_req && $urandom_range(0, 2) == 0) begin
            aud_req = 1;
            aud_addr = ADDR_W'($urandom_range(0, 255));
         end
         step();
      end
      finish_reqs();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
